pwm_multi: RTL and testbench

PWM_MULTI -- requirements
Module: pwm_multi

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_cmp.sv | 22 ++
 rtl/pwm_multi.sv | 160 ++++++++++++++++
 tb/tb_pwm_multi.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM block.
// Default counter width, channel count and counter direction.
package pwm_pkg;

  localparam int CW_DEF  = 8;
  localparam int NCH_DEF = 4;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/pwm_cmp.sv
// One PWM channel: compare shared count against duty, register result.
// Ports: clk, rst (sync, high), en, count, duty -> pwm (registered).
module pwm_cmp import pwm_pkg::*; #(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] count,
  input  logic [CW-1:0] duty,
  output logic          pwm
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm <= 1'b0;
    end else begin
      pwm <= en && (count < duty);
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shared counter and boundary-synchronous reload.
// Ports: clk, rst, en, period, duty, load -> pending, update,
// period_end, pwm_out. Macro PWM_CENTER_ALIGN_EN adds input center.
module pwm_multi import pwm_pkg::*; #(
  parameter int CW  = CW_DEF,
  parameter int NCH = NCH_DEF
) (
  input  logic              clk,
  input  logic              rst,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic              center,
`endif
  input  logic              en,
  input  logic [CW-1:0]     period,
  input  logic [NCH*CW-1:0] duty,
  input  logic              load,
  output logic              pending,
  output logic              update,
  output logic              period_end,
  output logic [NCH-1:0]    pwm_out
);

  logic [CW-1:0]     count;
  logic [CW-1:0]     count_n;
  logic [CW-1:0]     act_per;
  logic [CW-1:0]     stg_per;
  logic [NCH*CW-1:0] act_duty;
  logic [NCH*CW-1:0] stg_duty;
  logic              pend;
  logic              upd;
  logic              at_end;
  logic              bnd;
  logic              commit;

`ifdef PWM_CENTER_ALIGN_EN
  logic              act_ctr;
  logic              stg_ctr;
  logic              nxt_ctr;
  logic [CW-1:0]     nxt_per;
  dir_t              dir;
  dir_t              dir_n;

  // Center cycle ends on count 0 reached while counting down.
  always_comb begin
    at_end = 1'b0;
    if (act_ctr) begin
      at_end = (act_per == '0) ||
               (count == '0 && dir == DOWN);
    end else begin
      at_end = (count == act_per);
    end
  end
`else
  always_comb begin
    at_end = (count == act_per);
  end
`endif

  // A disabled block treats every clock as a boundary.
  assign bnd    = !en || at_end;
  assign commit = bnd && pend;

`ifdef PWM_CENTER_ALIGN_EN
  assign nxt_ctr = commit ? stg_ctr : act_ctr;
  assign nxt_per = commit ? stg_per : act_per;

  always_comb begin
    count_n = '0;
    dir_n   = UP;
    if (en && !at_end) begin
      if (!act_ctr) begin
        count_n = count + 1'b1;
      end else if (dir == UP && count == act_per) begin
        count_n = count - 1'b1;
        dir_n   = DOWN;
      end else if (dir == UP) begin
        count_n = count + 1'b1;
      end else begin
        count_n = count - 1'b1;
        dir_n   = DOWN;
      end
    end else if (en) begin
      // Center-to-center wrap skips the repeated 0.
      if (act_ctr && nxt_ctr && nxt_per != '0) begin
        count_n = {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end
`else
  always_comb begin
    count_n = '0;
    if (en && !at_end) begin
      count_n = count + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      act_per  <= '0;
      stg_per  <= '0;
      act_duty <= '0;
      stg_duty <= '0;
      pend     <= 1'b0;
      upd      <= 1'b0;
    end else begin
      count <= count_n;
      upd   <= commit;
      if (commit) begin
        act_per  <= stg_per;
        act_duty <= stg_duty;
      end
      // A load always stages; it wins over a same-cycle commit clear.
      if (load) begin
        stg_per  <= period;
        stg_duty <= duty;
        pend     <= 1'b1;
      end else if (commit) begin
        pend <= 1'b0;
      end
    end
  end

`ifdef PWM_CENTER_ALIGN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      act_ctr <= 1'b0;
      stg_ctr <= 1'b0;
      dir     <= UP;
    end else begin
      dir <= dir_n;
      if (commit) begin
        act_ctr <= stg_ctr;
      end
      if (load) begin
        stg_ctr <= center;
      end
    end
  end
`endif

  assign pending    = pend;
  assign update     = upd;
  assign period_end = en && !rst && at_end;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_cmp #(
      .CW(CW)
    ) u_cmp (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .count(count),
      .duty (act_duty[i*CW +: CW]),
      .pwm  (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed self-checking bench for pwm_multi (CW=8, NCH=4).
// Drives and samples on the falling clock edge.
module tb_pwm_multi;

  localparam int CW  = 8;
  localparam int NCH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [CW-1:0]     period;
  logic [NCH*CW-1:0] duty;
  logic              load;
  logic              pending;
  logic              update;
  logic              period_end;
  logic [NCH-1:0]    pwm_out;
`ifdef PWM_CENTER_ALIGN_EN
  logic              center;
`endif

  int total = 0;
  int bad   = 0;
  int hc [NCH];
  int pecnt;
  int n;

  always #5 clk = ~clk;

  pwm_multi #(
    .CW (CW),
    .NCH(NCH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef PWM_CENTER_ALIGN_EN
    .center    (center),
`endif
    .en        (en),
    .period    (period),
    .duty      (duty),
    .load      (load),
    .pending   (pending),
    .update    (update),
    .period_end(period_end),
    .pwm_out   (pwm_out)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Clocks until the next period_end, bounded.
  task automatic wait_pe(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!period_end && cnt < 64);
    chk("pe_seen", {31'd0, period_end}, 32'd1);
  endtask

  task automatic count_win(input int len);
    for (int i = 0; i < NCH; i++) hc[i] = 0;
    pecnt = 0;
    repeat (len) begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) hc[i] += int'(pwm_out[i]);
      pecnt += int'(period_end);
    end
  endtask

  task automatic chk_win(input string tag,
                         input int e0, input int e1,
                         input int e2, input int e3,
                         input int epe);
    chk({tag, "_ch0"}, hc[0], e0);
    chk({tag, "_ch1"}, hc[1], e1);
    chk({tag, "_ch2"}, hc[2], e2);
    chk({tag, "_ch3"}, hc[3], e3);
    chk({tag, "_pe"},  pecnt, epe);
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    load   = 1'b0;
    period = '0;
    duty   = '0;
`ifdef PWM_CENTER_ALIGN_EN
    center = 1'b0;
`endif
    tick();
    tick();
    chk("rst_pend", pending, 0);
    chk("rst_upd", update, 0);
    chk("rst_pe", period_end, 0);
    chk("rst_pwm", pwm_out, 0);
    rst = 1'b0;

    // Duty patterns 0,3,9,10 over period 9
    period = 8'd9;
    duty   = {8'd10, 8'd9, 8'd3, 8'd0};
    load   = 1'b1;
    tick();
    load = 1'b0;
    chk("ld_pend", pending, 1);
    tick();
    chk("dis_upd", update, 1);
    chk("dis_pend", pending, 0);
    en = 1'b1;
    wait_pe(n);
    wait_pe(n);
    chk("len10", n, 10);
    count_win(10);
    chk_win("w10", 0, 3, 9, 10, 1);

    // Load mid-cycle at count 2, period 4
    repeat (3) tick();
    period = 8'd4;
    load   = 1'b1;
    tick();
    load = 1'b0;
    chk("mid_pend", pending, 1);
    chk("mid_upd", update, 0);
    wait_pe(n);
    chk("to_end9", n, 6);
    chk("end_pend", pending, 1);
    tick();
    chk("cm_upd", update, 1);
    chk("cm_pend", pending, 0);
    wait_pe(n);
    chk("len5a", n, 4);
    count_win(5);
    chk_win("w5", 0, 3, 5, 5, 1);

    // Load coinciding with a boundary
    tick();
    period = 8'd6;
    load   = 1'b1;
    tick();
    load = 1'b0;
    chk("co_pend", pending, 1);
    wait_pe(n);
    period = 8'd7;
    load   = 1'b1;
    tick();
    load = 1'b0;
    chk("co_upd", update, 1);
    chk("co_keep", pending, 1);
    wait_pe(n);
    chk("len7", n, 6);
    tick();
    chk("co2_upd", update, 1);
    chk("co2_pend", pending, 0);
    wait_pe(n);
    chk("len8", n, 7);

    // Disable mid-cycle with a load in flight
    repeat (3) tick();
    period = 8'd3;
    duty   = {8'd4, 8'd2, 8'd1, 8'd0};
    load   = 1'b1;
    en     = 1'b0;
    tick();
    load = 1'b0;
    chk("off_pwm", pwm_out, 0);
    chk("off_pend", pending, 1);
    chk("off_pe", period_end, 0);
    tick();
    chk("off_upd", update, 1);
    chk("off_pend2", pending, 0);
    chk("off_pwm2", pwm_out, 0);
    en = 1'b1;
    wait_pe(n);
    chk("restart", n, 3);
    count_win(4);
    chk_win("w4", 0, 1, 2, 4, 1);

    // Period 0: boundary every clock
    en     = 1'b0;
    period = 8'd0;
    duty   = {8'd0, 8'd1, 8'd1, 8'd0};
    load   = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk("p0_upd", update, 1);
    en = 1'b1;
    tick();
    count_win(3);
    chk_win("w1", 0, 3, 3, 0, 3);

    // Reset mid-cycle with pending
    period = 8'd9;
    load   = 1'b1;
    tick();
    load = 1'b0;
    wait_pe(n);
    repeat (3) tick();
    period = 8'd2;
    load   = 1'b1;
    tick();
    load = 1'b0;
    chk("pre_rst_pend", pending, 1);
    rst = 1'b1;
    tick();
    tick();
    chk("mrst_pend", pending, 0);
    chk("mrst_upd", update, 0);
    chk("mrst_pe", period_end, 0);
    chk("mrst_pwm", pwm_out, 0);
    rst = 1'b0;
    tick();
    chk("post_pe", period_end, 1);
    chk("post_pwm", pwm_out, 0);
    chk("post_pend", pending, 0);

`ifdef PWM_CENTER_ALIGN_EN
    en     = 1'b0;
    center = 1'b1;
    period = 8'd4;
    duty   = {4{8'd2}};
    load   = 1'b1;
    tick();
    load = 1'b0;
    tick();
    en = 1'b1;
    wait_pe(n);
    wait_pe(n);
    chk("ctr_len", n, 8);
    count_win(8);
    chk_win("wc", 3, 3, 3, 3, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
